// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game controller: random wait, GO LED, BCD
// reaction count and best-time tracking.
module reaction_timer_ctrl #(
  parameter int DELAY_UNIT = 25,
  parameter int MAX_BCD    = 9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic [3:0]  rand_val,
  input  logic        start_btn,
  input  logic        stop_btn,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd,
  output logic        go_led,
  output logic        early_led,
  output logic [2:0]  state
);

  localparam int WW = $clog2(16 * DELAY_UNIT + 1);

  localparam logic [15:0] MAX_V = {
    4'(MAX_BCD / 1000 % 10), 4'(MAX_BCD / 100 % 10),
    4'(MAX_BCD / 10 % 10),   4'(MAX_BCD % 10)
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    EARLY = 3'd4
  } st_t;

  st_t cur;
  st_t nxt;

  logic [1:0]    sa_sync;
  logic [1:0]    so_sync;
  logic          sa_prev;
  logic          so_prev;
  logic          start_p;
  logic          stop_p;
  logic [WW-1:0] cnt;
  logic          load;
  logic          dec;
  logic          inc;
  logic          upd;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // MSD-first magnitude compare; first differing digit decides.
  function automatic logic bcd_lt(input logic [15:0] a,
                                  input logic [15:0] b);
    logic lt;
    logic hit;
    lt  = 1'b0;
    hit = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!hit && a[4*i +: 4] != b[4*i +: 4]) begin
        lt  = a[4*i +: 4] < b[4*i +: 4];
        hit = 1'b1;
      end
    end
    return lt;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sa_sync <= 2'b11;
      so_sync <= 2'b11;
      sa_prev <= 1'b1;
      so_prev <= 1'b1;
      start_p <= 1'b0;
      stop_p  <= 1'b0;
    end else begin
      sa_sync <= {sa_sync[0], start_btn};
      so_sync <= {so_sync[0], stop_btn};
      sa_prev <= sa_sync[1];
      so_prev <= so_sync[1];
      start_p <= sa_prev & ~sa_sync[1];
      stop_p  <= so_prev & ~so_sync[1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE, EARLY: if (start_p) nxt = WAIT;
      WAIT: begin
        if (stop_p) begin
          nxt = EARLY;
        end else if (tick && cnt == WW'(1)) begin
          nxt = GO;
        end
      end
      GO:      if (stop_p) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Stop press always beats a same-cycle tick.
  always_comb begin
    go_led    = (cur == GO);
    early_led = (cur == EARLY);
    load      = (cur == IDLE || cur == EARLY) && start_p;
    dec       = (cur == WAIT) && tick && !stop_p;
    inc       = (cur == GO) && tick && !stop_p;
    upd       = (cur == DONE) && bcd_lt(time_bcd, best_bcd);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      time_bcd <= 16'h0000;
      best_bcd <= 16'h9999;
    end else begin
      if (load) begin
        cnt      <= WW'({1'b0, rand_val} + 5'd1) * WW'(DELAY_UNIT);
        time_bcd <= 16'h0000;
      end else if (dec) begin
        cnt <= cnt - WW'(1);
      end else if (inc && time_bcd != MAX_V) begin
        time_bcd <= bcd_inc(time_bcd);
      end
      if (upd) begin
        best_bcd <= time_bcd;
      end
    end
  end

  assign state = cur;

endmodule
